// File: rtl/note_sequencer_if.sv
// Bus bundle between the note sequencer and its controller: table write port,
// playback controls and the divider-facing outputs.
interface note_sequencer_if #(
    parameter int N      = 8,
    parameter int DUR_W  = 8,
    parameter int ADDR_W = 4,
    parameter int TDIV_W = 16
);
    logic                 wr_en_i;
    logic [ADDR_W-1:0]    wr_addr_i;
    logic [N+DUR_W:0]     wr_data_i;
    logic                 start_i;
    logic                 stop_i;
    logic                 loop_i;
    logic [TDIV_W-1:0]    tick_div_i;
    logic [N-1:0]         maxval_o;
    logic                 div_rst_o;
    logic                 gate_o;
    logic                 busy_o;
    logic                 done_o;
    logic [ADDR_W-1:0]    addr_o;

    modport master (
        output wr_en_i, wr_addr_i, wr_data_i, start_i, stop_i, loop_i, tick_div_i,
        input  maxval_o, div_rst_o, gate_o, busy_o, done_o, addr_o
    );

    modport slave (
        input  wr_en_i, wr_addr_i, wr_data_i, start_i, stop_i, loop_i, tick_div_i,
        output maxval_o, div_rst_o, gate_o, busy_o, done_o, addr_o
    );
endinterface

// File: rtl/note_sequencer.sv
// Melody sequencer: steps a programmable note table at a programmable tempo and
// drives the clock divider's compare value, phase-align reset and output gate.
module note_sequencer #(
    parameter int N      = 8,
    parameter int DUR_W  = 8,
    parameter int ADDR_W = 4,
    parameter int TDIV_W = 16
) (
    input logic             clk_i,
    input logic             reset,
    note_sequencer_if.slave bus
);
    localparam int W = N + DUR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_LATCH, S_PLAY} state_t;

    state_t              state;
    logic [W-1:0]        mem [2**ADDR_W];
    logic [W-1:0]        rd_q;
    logic [N-1:0]        maxval_q;
    logic                div_rst_q;
    logic                gate_q;
    logic                done_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DUR_W-1:0]    dur_q;
    logic [DUR_W-1:0]    tcnt;
    logic                last_q;
    logic [TDIV_W-1:0]   pre;

    logic [N-1:0]        rd_pitch;
    logic [DUR_W-1:0]    rd_dur;
    logic                rd_last;
    logic [DUR_W:0]      dur_eff;
    logic [DUR_W:0]      tcnt_nxt;
    logic                tick;
    logic                note_end;
    logic                at_end;

    // Table is not reset; the read port always follows addr_q so the word
    // fetched in FETCH is ready to be latched in LATCH.
    always_ff @(posedge clk_i) begin
        if (bus.wr_en_i)
            mem[bus.wr_addr_i] <= bus.wr_data_i;
        rd_q <= mem[addr_q];
    end

    assign rd_pitch = rd_q[N-1:0];
    assign rd_dur   = rd_q[N +: DUR_W];
    assign rd_last  = rd_q[W-1];

    // A zero duration still plays for one tick.
    assign dur_eff  = (dur_q == '0) ? (DUR_W+1)'(1) : {1'b0, dur_q};
    assign tcnt_nxt = {1'b0, tcnt} + (DUR_W+1)'(1);
    assign tick     = (pre >= bus.tick_div_i);
    assign note_end = tick && (tcnt_nxt >= dur_eff);
    assign at_end   = last_q || (addr_q == '1);

    always_ff @(posedge clk_i) begin
        if (reset) begin
            state     <= S_IDLE;
            maxval_q  <= '0;
            div_rst_q <= 1'b0;
            gate_q    <= 1'b0;
            done_q    <= 1'b0;
            addr_q    <= '0;
            dur_q     <= '0;
            last_q    <= 1'b0;
            tcnt      <= '0;
            pre       <= '0;
        end else begin
            div_rst_q <= 1'b0;
            done_q    <= 1'b0;
            if (bus.stop_i) begin
                state  <= S_IDLE;
                gate_q <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (bus.start_i) begin
                            addr_q <= '0;
                            state  <= S_FETCH;
                        end
                    end
                    S_FETCH: begin
                        gate_q <= 1'b0;
                        state  <= S_LATCH;
                    end
                    S_LATCH: begin
                        // Rests keep the previous compare value so the divider
                        // does not see a zero maxval mid-melody.
                        if (rd_pitch != '0)
                            maxval_q <= rd_pitch;
                        gate_q    <= (rd_pitch != '0);
                        dur_q     <= rd_dur;
                        last_q    <= rd_last;
                        div_rst_q <= 1'b1;
                        tcnt      <= '0;
                        pre       <= '0;
                        state     <= S_PLAY;
                    end
                    S_PLAY: begin
                        if (tick) begin
                            pre  <= '0;
                            tcnt <= tcnt_nxt[DUR_W-1:0];
                        end else begin
                            pre  <= pre + TDIV_W'(1);
                        end
                        if (note_end) begin
                            gate_q <= 1'b0;
                            if (!at_end) begin
                                addr_q <= addr_q + ADDR_W'(1);
                                state  <= S_FETCH;
                            end else if (bus.loop_i) begin
                                addr_q <= '0;
                                state  <= S_FETCH;
                            end else begin
                                done_q <= 1'b1;
                                state  <= S_IDLE;
                            end
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.maxval_o  = maxval_q;
    assign bus.div_rst_o = div_rst_q;
    assign bus.gate_o    = gate_q;
    assign bus.busy_o    = (state != S_IDLE);
    assign bus.done_o    = done_q;
    assign bus.addr_o    = addr_q;
endmodule

// File: tb/tb_note_sequencer.sv
// Self-checking bench for note_sequencer: table-driven two-note melodies checked
// through a note scoreboard, plus hand sequences for loop/stop/start/reset cases.
module tb_note_sequencer;
    localparam int N = 8, DUR_W = 8, ADDR_W = 4, TDIV_W = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    note_sequencer_if #(.N(N), .DUR_W(DUR_W), .ADDR_W(ADDR_W), .TDIV_W(TDIV_W)) bus ();

    note_sequencer #(.N(N), .DUR_W(DUR_W), .ADDR_W(ADDR_W), .TDIV_W(TDIV_W)) dut (
        .clk_i (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct { int mv; int g; int len; } note_t;
    typedef struct {
        logic [N+DUR_W:0] w0, w1;
        int tdiv;
        int m0, g0, l0, m1, g1, l1;
    } vec_t;

    note_t sb[$];
    note_t cur;
    vec_t  vecs[5];
    int    n_cmp = 0, n_err = 0, done_cnt = 0, cnt = 0;
    bit    active = 0, mon_en = 0;

    function automatic logic [N+DUR_W:0] ent(bit last, int dur, int pitch);
        return {last, DUR_W'(dur), N'(pitch)};
    endfunction

    task automatic chk(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Scoreboard monitor: each div_rst pulse pops the next expected note;
    // note length is measured up to the next pulse (minus 2 gap clocks) or idle.
    always @(negedge clk) begin
        if (bus.done_o) done_cnt++;
        if (!mon_en) active = 0;
        else if (bus.div_rst_o) begin
            if (active) chk("note_len", cnt - 2, cur.len);
            chk("note_expected", int'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                cur = sb.pop_front();
                chk("note_maxval", int'(bus.maxval_o), cur.mv);
                chk("note_gate", int'(bus.gate_o), cur.g);
                active = 1;
                cnt = 1;
            end else active = 0;
        end else if (active) begin
            if (!bus.busy_o) begin
                chk("note_len_end", cnt, cur.len);
                active = 0;
            end else begin
                cnt++;
                chk("gate_hold", int'(bus.gate_o), (cnt <= cur.len) ? cur.g : 0);
            end
        end
    end

    task automatic step(int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(int a, logic [N+DUR_W:0] d);
        bus.wr_en_i   = 1'b1;
        bus.wr_addr_i = ADDR_W'(a);
        bus.wr_data_i = d;
        step();
        bus.wr_en_i   = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(2);
        reset = 1'b0;
    endtask

    // Start lands on edge k; div_rst must appear at the third negedge after it.
    task automatic start_lat(string name);
        int n;
        bus.start_i = 1'b1;
        step();
        bus.start_i = 1'b0;
        n = 1;
        while (!bus.div_rst_o && n < 20) begin
            step();
            n++;
        end
        chk(name, n, 3);
    endtask

    task automatic wait_idle(string name);
        int n;
        n = 0;
        while (bus.busy_o && n < 5000) begin
            step();
            n++;
        end
        chk(name, int'(bus.busy_o), 0);
    endtask

    task automatic wait_sig_div_rst(string name);
        int n;
        n = 0;
        while (!bus.div_rst_o && n < 50) begin
            step();
            n++;
        end
        chk(name, int'(bus.div_rst_o), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int mv_hold;
        bus.wr_en_i = 0; bus.wr_addr_i = '0; bus.wr_data_i = '0;
        bus.start_i = 0; bus.stop_i = 0; bus.loop_i = 0; bus.tick_div_i = '0;

        vecs[0] = '{ent(0,2,40), ent(1,3,60),  4,  40,1,10,  60,1,15};
        vecs[1] = '{ent(0,1,0),  ent(1,1,25),  1,   0,0, 2,  25,1, 2};
        vecs[2] = '{ent(0,0,7),  ent(1,5,9),   0,   7,1, 1,   9,1, 5};
        vecs[3] = '{ent(0,3,200),ent(1,0,0),   2, 200,1, 9, 200,0, 3};
        vecs[4] = '{ent(0,4,1),  ent(1,2,255), 3,   1,1,16, 255,1, 8};

        // Reset state
        reset = 1'b1;
        step(2);
        chk("rst_maxval", int'(bus.maxval_o), 0);
        chk("rst_div_rst", int'(bus.div_rst_o), 0);
        chk("rst_gate", int'(bus.gate_o), 0);
        chk("rst_busy", int'(bus.busy_o), 0);
        chk("rst_done", int'(bus.done_o), 0);
        chk("rst_addr", int'(bus.addr_o), 0);
        reset = 1'b0;

        // Two-note melodies
        foreach (vecs[i]) begin
            do_reset();
            wr(0, vecs[i].w0);
            wr(1, vecs[i].w1);
            bus.tick_div_i = TDIV_W'(vecs[i].tdiv);
            mon_en = 1;
            sb.push_back('{vecs[i].m0, vecs[i].g0, vecs[i].l0});
            sb.push_back('{vecs[i].m1, vecs[i].g1, vecs[i].l1});
            done_cnt = 0;
            start_lat($sformatf("vec%0d_latency", i));
            wait_idle($sformatf("vec%0d_idle", i));
            step();
            chk($sformatf("vec%0d_done", i), done_cnt, 1);
            chk($sformatf("vec%0d_sb_empty", i), sb.size(), 0);
            chk($sformatf("vec%0d_maxval_end", i), int'(bus.maxval_o), vecs[i].m1);
            chk($sformatf("vec%0d_gate_end", i), int'(bus.gate_o), 0);
        end

        // Full 16-entry table without last flag, dur=0, fastest tempo
        do_reset();
        for (int i = 0; i < 16; i++) wr(i, ent(0, 0, i + 1));
        bus.tick_div_i = '0;
        for (int i = 0; i < 16; i++) sb.push_back('{i + 1, 1, 1});
        done_cnt = 0;
        start_lat("full_latency");
        wait_idle("full_idle");
        step();
        chk("full_done", done_cnt, 1);
        chk("full_sb_empty", sb.size(), 0);
        chk("full_addr_end", int'(bus.addr_o), 15);

        // Looping playback then stop mid-note
        mon_en = 0;
        do_reset();
        wr(0, ent(0, 1, 10));
        wr(1, ent(1, 1, 20));
        bus.tick_div_i = TDIV_W'(1);
        bus.loop_i = 1'b1;
        done_cnt = 0;
        start_lat("loop_latency");
        for (int k = 0; k < 6; k++) begin
            wait_sig_div_rst("loop_pulse");
            chk("loop_addr", int'(bus.addr_o), k % 2);
            chk("loop_maxval", int'(bus.maxval_o), (k % 2) ? 20 : 10);
            step();
        end
        chk("loop_gate_mid", int'(bus.gate_o), 1);
        mv_hold = int'(bus.maxval_o);
        bus.stop_i = 1'b1;
        step();
        bus.stop_i = 1'b0;
        chk("stop_busy", int'(bus.busy_o), 0);
        chk("stop_gate", int'(bus.gate_o), 0);
        chk("stop_div_rst", int'(bus.div_rst_o), 0);
        chk("stop_maxval_hold", int'(bus.maxval_o), mv_hold);
        step(4);
        chk("stop_no_done", done_cnt, 0);
        chk("stop_stays_idle", int'(bus.busy_o), 0);
        bus.loop_i = 1'b0;

        // stop and start together in IDLE
        bus.stop_i = 1'b1;
        bus.start_i = 1'b1;
        step();
        bus.stop_i = 1'b0;
        bus.start_i = 1'b0;
        chk("stop_start_idle", int'(bus.busy_o), 0);
        step(2);
        chk("stop_start_idle2", int'(bus.busy_o), 0);

        // Start ignored while busy; live rewrite of entry 1
        do_reset();
        wr(0, ent(0, 4, 30));
        wr(1, ent(1, 1, 50));
        bus.tick_div_i = TDIV_W'(3);
        mon_en = 1;
        sb.push_back('{30, 1, 16});
        sb.push_back('{77, 1, 4});
        done_cnt = 0;
        start_lat("live_latency");
        step(4);
        wr(1, ent(1, 1, 77));
        bus.start_i = 1'b1;
        step();
        bus.start_i = 1'b0;
        wait_idle("live_idle");
        step();
        chk("live_done", done_cnt, 1);
        chk("live_sb_empty", sb.size(), 0);

        // Reset asserted mid-note
        mon_en = 0;
        start_lat("rstmid_latency");
        step(3);
        chk("rstmid_playing", int'(bus.gate_o), 1);
        reset = 1'b1;
        step();
        chk("rstmid_maxval", int'(bus.maxval_o), 0);
        chk("rstmid_gate", int'(bus.gate_o), 0);
        chk("rstmid_busy", int'(bus.busy_o), 0);
        chk("rstmid_addr", int'(bus.addr_o), 0);
        chk("rstmid_div_rst", int'(bus.div_rst_o), 0);
        reset = 1'b0;
        step(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
